// File: rtl/dmem_responder.sv
// Data-memory responder: word load/store on an internal array with a
// programmable number of wait states, stalling the datapath until done.
module dmem_responder #(
   parameter int DATA_WIDTH  = 32,
   parameter int DEPTH_LOG2  = 10,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  mem_rd,
   input  logic                  mem_wr,
   input  logic [DATA_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  stall,
   output logic                  done,
   output logic                  err
);

   typedef enum logic [1:0] {IDLE, WAIT, ACCESS, DONE} state_t;

   localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   state_t                  state_q, state_d;
   logic [3:0]              cnt_q;
   logic                    op_wr_q;
   logic [DEPTH_LOG2-1:0]   idx_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic [DATA_WIDTH-1:0]   mem [0:(2**DEPTH_LOG2)-1];

   logic                    req, bad, accept, reject;
   logic                    unused_addr_bits;

   // Upper address bits only select aliases of the same word.
   always_comb unused_addr_bits = ^addr[DATA_WIDTH-1:DEPTH_LOG2+2];

   // Request decode, next-state and stall.
   always_comb begin
      req     = mem_rd | mem_wr;
      bad     = (mem_rd & mem_wr) | (addr[1:0] != 2'b00);
      accept  = (state_q == IDLE) & req & ~bad;
      reject  = (state_q == IDLE) & req & bad;
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = (WAIT_CYCLES > 0) ? WAIT : ACCESS;
         WAIT:    if (cnt_q == '0) state_d = ACCESS;
         ACCESS:  state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      stall = accept | (state_q == WAIT) | (state_q == ACCESS);
   end

   // State register, request latch, wait counter and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         op_wr_q <= 1'b0;
         idx_q   <= '0;
         wdata_q <= '0;
         rdata   <= '0;
         done    <= 1'b0;
         err     <= 1'b0;
      end else begin
         state_q <= state_d;
         done    <= (state_q == ACCESS);
         err     <= reject;
         if (accept) begin
            op_wr_q <= mem_wr;
            idx_q   <= addr[DEPTH_LOG2+1:2];
            wdata_q <= wdata;
            cnt_q   <= WAIT_LOAD;
         end else if (state_q == WAIT && cnt_q != '0) begin
            cnt_q <= cnt_q - 4'd1;
         end
         if (state_q == ACCESS && !op_wr_q) rdata <= mem[idx_q];
      end
   end

   // Array write; not reset, and a reset before ACCESS leaves it untouched.
   always_ff @(posedge clk) begin
      if (state_q == ACCESS && op_wr_q) mem[idx_q] <= wdata_q;
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: vector table + response scoreboard.
module tb_dmem_responder;

   localparam int W = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_rd, mem_wr;
   logic [31:0] addr, wdata, rdata;
   logic        stall, done, err;

   logic        rd0, wr0;
   logic [31:0] addr0, wdata0, rdata0;
   logic        stall0, done0, err0;

   int checks = 0;
   int passes = 0;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        exp_err;
      logic [31:0] exp_rdata;
   } vec_t;

   typedef struct {
      logic        is_err;
      logic [31:0] rd;
   } exp_t;

   vec_t vecs [15];
   exp_t sbq [$];

   dmem_responder #(.DATA_WIDTH(32), .DEPTH_LOG2(10), .WAIT_CYCLES(W)) u_dut (
      .clk(clk), .rst_n(rst_n), .mem_rd(mem_rd), .mem_wr(mem_wr), .addr(addr),
      .wdata(wdata), .rdata(rdata), .stall(stall), .done(done), .err(err)
   );

   dmem_responder #(.DATA_WIDTH(32), .DEPTH_LOG2(10), .WAIT_CYCLES(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .mem_rd(rd0), .mem_wr(wr0), .addr(addr0),
      .wdata(wdata0), .rdata(rdata0), .stall(stall0), .done(done0), .err(err0)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Every done/err pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_n && (done || err)) begin
         if (sbq.size() == 0) begin
            chk("unexpected_resp", {30'd0, done, err}, 32'd0);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            chk("resp_err", {31'd0, err}, {31'd0, e.is_err});
            chk("resp_done", {31'd0, done}, {31'd0, ~e.is_err});
            if (!e.is_err) chk("rdata", rdata, e.rd);
         end
      end
   end

   task automatic apply(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic exp_err, input logic [31:0] exp_rd);
      int  n;
      bit  seen;
      @(posedge clk); #1;
      mem_rd = rd; mem_wr = wr; addr = a; wdata = d;
      sbq.push_back('{is_err: exp_err, rd: exp_rd});
      @(negedge clk);
      chk("stall_req", {31'd0, stall}, {31'd0, ~exp_err});
      @(posedge clk); #1;
      mem_rd = 1'b0; mem_wr = 1'b0; addr = $urandom; wdata = $urandom;
      if (exp_err) begin
         @(negedge clk);
         chk("stall_rej", {31'd0, stall}, 32'd0);
         @(negedge clk);
         chk("err_pulse", {31'd0, err}, 32'd0);
      end else begin
         n = 0; seen = 0;
         while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (done) seen = 1;
            else chk("stall_busy", {31'd0, stall}, 32'd1);
         end
         chk("latency", n, W + 2);
         chk("stall_in_done", {31'd0, stall}, 32'd0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0]  = '{1'b0, 1'b1, 32'h10,   32'hDEADBEEF, 1'b0, 32'h0};
      vecs[1]  = '{1'b1, 1'b0, 32'h10,   32'h0,        1'b0, 32'hDEADBEEF};
      vecs[2]  = '{1'b0, 1'b1, 32'h20,   32'hCAFEF00D, 1'b0, 32'hDEADBEEF};
      vecs[3]  = '{1'b1, 1'b1, 32'h20,   32'h0BADBAD0, 1'b1, 32'h0};
      vecs[4]  = '{1'b1, 1'b0, 32'h20,   32'h0,        1'b0, 32'hCAFEF00D};
      vecs[5]  = '{1'b0, 1'b1, 32'h22,   32'h55555555, 1'b1, 32'h0};
      vecs[6]  = '{1'b1, 1'b0, 32'h20,   32'h0,        1'b0, 32'hCAFEF00D};
      vecs[7]  = '{1'b0, 1'b1, 32'h1004, 32'h12345678, 1'b0, 32'hCAFEF00D};
      vecs[8]  = '{1'b1, 1'b0, 32'h4,    32'h0,        1'b0, 32'h12345678};
      vecs[9]  = '{1'b0, 1'b1, 32'hFFC,  32'hA5A5C3C3, 1'b0, 32'h12345678};
      vecs[10] = '{1'b1, 1'b0, 32'hFFC,  32'h0,        1'b0, 32'hA5A5C3C3};
      vecs[11] = '{1'b1, 1'b0, 32'h1004, 32'h0,        1'b0, 32'h12345678};
      vecs[12] = '{1'b1, 1'b0, 32'h13,   32'h0,        1'b1, 32'h0};
      vecs[13] = '{1'b0, 1'b1, 32'h10,   32'h01020304, 1'b0, 32'h12345678};
      vecs[14] = '{1'b1, 1'b0, 32'h10,   32'h0,        1'b0, 32'h01020304};

      rst_n = 1'b0;
      mem_rd = 1'b0; mem_wr = 1'b0; addr = '0; wdata = '0;
      rd0 = 1'b0; wr0 = 1'b0; addr0 = '0; wdata0 = '0;
      #1;
      chk("rst_stall", {31'd0, stall}, 32'd0);
      chk("rst_done",  {31'd0, done},  32'd0);
      chk("rst_err",   {31'd0, err},   32'd0);
      chk("rst_rdata", rdata, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Zero-wait instance: continuous mem_rd gives one access every 3 cycles.
      @(posedge clk); #1;
      wr0 = 1'b1; addr0 = 32'h10; wdata0 = 32'h13572468;
      @(posedge clk); #1;
      wr0 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rd0 = 1'b1; addr0 = 32'h10;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         chk("w0_done",  {31'd0, done0},  {31'd0, (c % 3) == 2});
         chk("w0_stall", {31'd0, stall0}, {31'd0, (c % 3) != 2});
         chk("w0_err",   {31'd0, err0},   32'd0);
         if ((c % 3) == 2) chk("w0_rdata", rdata0, 32'h13572468);
      end
      @(posedge clk); #1;
      rd0 = 1'b0;
      repeat (3) @(posedge clk);

      for (int i = 0; i < 15; i++)
         apply(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
               vecs[i].exp_err, vecs[i].exp_rdata);

      // Reset during WAIT discards the pending store.
      apply(1'b0, 1'b1, 32'h40, 32'h11111111, 1'b0, 32'h01020304);
      apply(1'b0, 1'b1, 32'h44, 32'h00000000, 1'b0, 32'h01020304);
      @(posedge clk); #1;
      mem_wr = 1'b1; addr = 32'h40; wdata = 32'hAAAA5555;
      @(negedge clk);
      chk("abort_stall_req", {31'd0, stall}, 32'd1);
      @(posedge clk); #1;
      mem_wr = 1'b0;
      @(negedge clk);
      chk("abort_stall_wait", {31'd0, stall}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_stall", {31'd0, stall}, 32'd0);
      chk("abort_done",  {31'd0, done},  32'd0);
      chk("abort_rdata", rdata, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("abort_no_done", {31'd0, done}, 32'd0);
      end
      apply(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 32'h11111111);

      // Reset during DONE keeps the completed store but suppresses done.
      @(posedge clk); #1;
      mem_wr = 1'b1; addr = 32'h44; wdata = 32'h77777777;
      @(posedge clk); #1;
      mem_wr = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("late_rst_done",  {31'd0, done},  32'd0);
      chk("late_rst_stall", {31'd0, stall}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      apply(1'b1, 1'b0, 32'h44, 32'h0, 1'b0, 32'h77777777);

      repeat (4) @(posedge clk);
      chk("sb_drain", 32'(sbq.size()), 32'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
